// File: rtl/uart_rx_led_app.sv
// 8N1 UART receiver driving a one-hot LED command display with an idle timeout
// and a heartbeat toggled by '.' characters.
module uart_rx_led_app #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 300_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       uart_rx_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       rx_active_o,
  output logic [3:0] led_o,
  output logic       heartbeat_o,
  output logic       bad_char_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic             sync1_r, sync2_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shift_r, shift_s;
  logic [7:0]       byte_r, byte_s;
  logic             valid_r, valid_s;
  logic             ferr_r, ferr_s;
  logic             active_r;
  logic [TMO_W-1:0] tmo_r, tmo_s;
  logic [3:0]       led_r, led_s;
  logic             hb_r, hb_s;
  logic             bad_r, bad_s;

  // Two-flop synchronizer; idles high so reset looks like an idle line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= uart_rx_data_i;
      sync2_r <= sync1_r;
    end
  end

  // Receiver next-state, sampling and pulse generation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    byte_s  = byte_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_s = '0;
        idx_s = 3'd0;
        if (!sync2_r) state_s = S_START;
        else          state_s = S_IDLE;
      end
      S_START: begin
        if (cnt_r == CNT_MID) begin
          cnt_s = '0;
          if (!sync2_r) state_s = S_DATA;
          else          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s          = '0;
          shift_s[idx_r] = sync2_r;
          if (idx_r == 3'd7) begin
            idx_s   = 3'd0;
            state_s = S_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s = '0;
          if (sync2_r) begin
            byte_s  = shift_r;
            valid_s = 1'b1;
            state_s = S_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = S_WAIT_HIGH;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        cnt_s = '0;
        if (sync2_r) state_s = S_IDLE;
        else         state_s = S_WAIT_HIGH;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Receiver state and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      byte_r   <= 8'h00;
      valid_r  <= 1'b0;
      ferr_r   <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      byte_r   <= byte_s;
      valid_r  <= valid_s;
      ferr_r   <= ferr_s;
      active_r <= (state_s != S_IDLE);
    end
  end

  // Command decode and idle timeout; a valid byte always beats the timeout.
  always_comb begin
    led_s = led_r;
    hb_s  = hb_r;
    bad_s = 1'b0;
    tmo_s = tmo_r;
    if (valid_r) begin
      tmo_s = '0;
      case (byte_r)
        8'h61:   led_s = 4'b0001;
        8'h62:   led_s = 4'b0010;
        8'h63:   led_s = 4'b0100;
        8'h64:   led_s = 4'b1000;
        8'h2E:   hb_s  = ~hb_r;
        default: bad_s = 1'b1;
      endcase
    end else begin
      if (tmo_r != TMO_MAX) tmo_s = tmo_r + TMO_W'(1);
      else                  tmo_s = tmo_r;
      if (tmo_s == TMO_MAX) led_s = 4'b0000;
      else                  led_s = led_r;
    end
  end

  // Display registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_r <= '0;
      led_r <= 4'b0000;
      hb_r  <= 1'b0;
      bad_r <= 1'b0;
    end else begin
      tmo_r <= tmo_s;
      led_r <= led_s;
      hb_r  <= hb_s;
      bad_r <= bad_s;
    end
  end

  assign rx_byte_o      = byte_r;
  assign rx_valid_o     = valid_r;
  assign rx_frame_err_o = ferr_r;
  assign rx_active_o    = active_r;
  assign led_o          = led_r;
  assign heartbeat_o    = hb_r;
  assign bad_char_o     = bad_r;

endmodule

// File: tb/tb_uart_rx_led_app.sv
// Directed bench for uart_rx_led_app with a byte scoreboard checked on every
// rx_valid_o pulse.
module tb_uart_rx_led_app;

  localparam int CPB = 8;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_frame_err, rx_active, heartbeat, bad_char;
  logic [3:0] led;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0, ferr_cnt = 0, bad_cnt = 0, act_cnt = 0, last_valid = 0;
  int v0, f0, b0, t0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_b;
  logic [7:0] abort_b;

  uart_rx_led_app #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .uart_rx_data_i (rx_line),
    .rx_byte_o      (rx_byte),
    .rx_valid_o     (rx_valid),
    .rx_frame_err_o (rx_frame_err),
    .rx_active_o    (rx_active),
    .led_o          (led),
    .heartbeat_o    (heartbeat),
    .bad_char_o     (bad_char)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input int n);
    rx_line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    drv(1'b0, CPB);
    for (int i = 0; i < 8; i++) drv(b[i], CPB);
    drv(stop, CPB);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Output monitor and scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_active) act_cnt++;
      if (rx_frame_err) ferr_cnt++;
      if (bad_char) bad_cnt++;
      if (rx_valid || rx_frame_err)
        chk("valid_ferr_excl", {31'd0, rx_valid & rx_frame_err}, 32'd0);
      if (rx_valid) begin
        valid_cnt++;
        last_valid = cyc;
        chk("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          chk("sb_rx_byte", {24'd0, rx_byte}, {24'd0, exp_b});
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte", {24'd0, rx_byte}, 32'h00);
    chk("rst_led", {28'd0, led}, 32'h0);
    chk("rst_hb", {31'd0, heartbeat}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    chk("rst_bad", {31'd0, bad_char}, 32'd0);
    chk("rst_active", {31'd0, rx_active}, 32'd0);
    rst_n = 1'b1;
    drv(1'b1, 10);

    // 'b' lights LED 1; active spans about 9.5 bit periods
    v0 = valid_cnt;
    act_cnt = 0;
    sb_q.push_back(8'h62);
    send(8'h62, 1'b1);
    drv(1'b1, 6);
    chk("b_valid_cnt", valid_cnt - v0, 32'd1);
    chk("b_led", {28'd0, led}, 32'h2);
    chk("b_byte", {24'd0, rx_byte}, 32'h62);
    chk("b_active_len", {31'd0, (act_cnt >= 70 && act_cnt <= 82)}, 32'd1);

    // three back-to-back '.' frames
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(8'h2E);
      send(8'h2E, 1'b1);
    end
    drv(1'b1, 6);
    chk("dot_valid_cnt", valid_cnt - v0, 32'd3);
    chk("dot_hb", {31'd0, heartbeat}, 32'd1);
    chk("dot_led", {28'd0, led}, 32'h2);

    // framing error followed by a held-low break
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send(8'h41, 1'b0);
    drv(1'b0, 40);
    drv(1'b1, 10);
    chk("ferr_cnt", ferr_cnt - f0, 32'd1);
    chk("ferr_no_valid", valid_cnt - v0, 32'd0);
    chk("ferr_byte_hold", {24'd0, rx_byte}, 32'h2E);
    chk("ferr_led", {28'd0, led}, 32'h2);
    chk("ferr_hb", {31'd0, heartbeat}, 32'd1);

    // two-cycle glitch is rejected
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drv(1'b0, 2);
    drv(1'b1, 20);
    chk("glitch_no_valid", valid_cnt - v0, 32'd0);
    chk("glitch_no_ferr", ferr_cnt - f0, 32'd0);
    chk("glitch_idle", {31'd0, rx_active}, 32'd0);

    // 'a', then a bad char late in the timeout window, then full timeout
    sb_q.push_back(8'h61);
    send(8'h61, 1'b1);
    drv(1'b1, 6);
    chk("a_led", {28'd0, led}, 32'h1);
    while (cyc - last_valid < 850) @(negedge clk);
    b0 = bad_cnt;
    sb_q.push_back(8'h7A);
    send(8'h7A, 1'b1);
    drv(1'b1, 6);
    chk("z_bad_cnt", bad_cnt - b0, 32'd1);
    chk("z_led_kept", {28'd0, led}, 32'h1);
    t0 = last_valid;
    while (cyc - t0 < 990) @(negedge clk);
    chk("tmo_before", {28'd0, led}, 32'h1);
    while (cyc - t0 < 1010) @(negedge clk);
    chk("tmo_after", {28'd0, led}, 32'h0);
    chk("tmo_hb", {31'd0, heartbeat}, 32'd1);

    // reset in the middle of data bit 4
    v0 = valid_cnt;
    f0 = ferr_cnt;
    abort_b = 8'h64;
    drv(1'b0, CPB);
    for (int i = 0; i < 4; i++) drv(abort_b[i], CPB);
    drv(abort_b[4], 4);
    rst_n = 1'b0;
    #1;
    chk("abort_active", {31'd0, rx_active}, 32'd0);
    chk("abort_led", {28'd0, led}, 32'h0);
    chk("abort_byte", {24'd0, rx_byte}, 32'h00);
    chk("abort_hb", {31'd0, heartbeat}, 32'd0);
    chk("abort_valid", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    drv(1'b1, 10);
    rst_n = 1'b1;
    drv(1'b1, 20);
    chk("abort_no_valid", valid_cnt - v0, 32'd0);
    chk("abort_no_ferr", ferr_cnt - f0, 32'd0);
    sb_q.push_back(8'h63);
    send(8'h63, 1'b1);
    drv(1'b1, 6);
    chk("c_led", {28'd0, led}, 32'h4);
    chk("c_byte", {24'd0, rx_byte}, 32'h63);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
